awgn_scale_stream: RTL
======================

// Module: awgn_scale_stream
// PURPOSE
//  Post-processor for the Box-Muller noise generators. Takes one raw Gaussian sample per channel per
//  in_valid vector and serialises the NCH channels. Applies a programmable sigma gain with
//  round-half-up and saturation to OUT_W. Buffers results in a FIFO behind a valid/ready stream.
//  Discards the start-up zero samples. Counts vectors lost to overload.
// PARAMETERS
//  NCH     4   channels per input vector (>=2)
//  IN_W    16  raw sample width, signed two's complement
//  OUT_W   12  output sample width, signed (OUT_W <= IN_W)
//  GAIN_W  16  unsigned gain width
//  FRAC    14  gain fractional bits (gain == 2^FRAC is unity)
//  DEPTH   16  FIFO entries (>= NCH)
//  WARMUP  16  input vectors discarded after reset
// PORTS
//  clk       in   1             single clock, rising edge
//  rst       in   1             synchronous reset, active-high
//  enable    in   1             0: ignore in_valid (not counted as drops)
//  in_valid  in   1             in_data holds a new vector; no ready, source is free-running
//  in_data   in   NCH*IN_W      ch k at [k*IN_W +: IN_W]
//  gain      in   GAIN_W        sigma multiplier, sampled once per accepted vector
//  out_valid out  1             FIFO head valid
//  out_ready in   1             sink accepts head when out_valid & out_ready
//  out_data  out  OUT_W         scaled, saturated sample
//  out_ch    out  $clog2(NCH)   channel index of out_data
//  out_last  out  1             out_ch == NCH-1
//  warm      out  1             warm-up complete
//  drop_cnt  out  16            vectors dropped, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (rst high at an edge): FIFO, pipeline and serialiser cleared. warm/warm-up count,
//    drop_cnt, out_valid, out_data, out_ch, out_last = 0 after that edge. Reset mid-stream
//    discards all in-flight samples.
//  - Warm-up: the first WARMUP vectors with in_valid&enable are discarded (not drops). warm rises on
//    the edge that discards the WARMUP-th vector. The next vector is eligible.
//  - Accept at edge T iff: warm & enable & in_valid & serialiser idle &
//    (DEPTH - fifo_count - inflight) >= NCH. Whole vectors only; channel groups are never split.
//  - Drop: warm & enable & in_valid while not accepted -> drop_cnt+1 (saturating); no partial write.
//  - Serialiser: ch k of a vector accepted at edge T enters the multiplier at edge T+1+k.
//    Idle again so the next vector can be accepted at edge T+NCH. in_valid every cycle -> 1 accepted,
//    NCH-1 dropped.
//  - gain is latched at accept; one value applies to all NCH channels of that vector.
//  - Arithmetic: SH = FRAC+IN_W-OUT_W; p = x*gain (signed IN_W x unsigned GAIN_W, full width).
//    y = (p + 2^(SH-1)) >>> SH. Clamp y to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  - Pipeline: product registered at T+1+k; rounded/saturated at T+2+k; FIFO write at T+3+k.
//    If the FIFO was empty, out_valid is high after edge T+3 with ch0.
//  - FIFO is show-ahead and holds {ch,data}. Pop on out_valid&out_ready. Simultaneous push and
//    pop is allowed at any fill level. The credit rule makes overflow impossible.
//  - out_data/out_ch hold their value while out_valid & ~out_ready. Output order = accept order,
//    ch 0..NCH-1.
//  - enable low: no new accepts; in-flight samples and the FIFO drain normally.
// TESTING
//  1 Defaults, gain=16384, warm, in ch0..3 = 0x4000, 0xC000, 0x7FFF, 0x8000
//    -> out 0x400, 0xC00, 0x7FF (sat), 0x800; out_ch 0..3; out_last on ch3 only.
//  2 gain=32768, ch0=0x4000, ch1=0x1000, ch2=0xF000, ch3=0x0000
//    -> 0x7FF (sat), 0x200, 0xE00, 0x000.
//  3 out_ready=0, 5 vectors spaced 8 cycles -> 16 entries held, 5th dropped, drop_cnt=1.
//    Then out_ready=1 -> 16 beats in order, out_valid falls after the last.
//  4 After rst, 16 vectors -> no out_valid, drop_cnt=0, warm rises at the 16th. 17th vector -> output.
//  5 in_valid every cycle for 8 cycles (FIFO empty, warm) -> 2 vectors accepted, drop_cnt=6.
//    First out_valid 3 cycles after the first accept edge.
//  6 rst pulsed while FIFO holds 10 entries and 3 are in flight
//    -> out_valid=0 next edge, no stale beats, warm=0, drop_cnt=0.

Source files
------------

// File: rtl/awgn_scale_stream_if.sv
// Output sample stream of awgn_scale_stream.
// A show-ahead valid/ready beat that carries a channel tag and a last-channel marker.
interface awgn_scale_stream_if #(
    parameter int OUT_W = 12,
    parameter int CH_W  = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             out_last;

    modport master (output out_valid, out_data, out_ch, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_ch, out_last, output out_ready);
endinterface

// File: rtl/awgn_scale_stream.sv
// Gaussian noise post-processor. It serialises NCH raw samples, applies a sigma gain with
// round-half-up and saturation, and buffers the results in a credit-protected FIFO.
module awgn_scale_stream #(
    parameter int NCH    = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 12,
    parameter int GAIN_W = 16,
    parameter int FRAC   = 14,
    parameter int DEPTH  = 16,
    parameter int WARMUP = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    in_valid_i,
    input  logic [NCH*IN_W-1:0]     in_data_i,
    input  logic [GAIN_W-1:0]       gain_i,
    output logic                    warm_o,
    output logic [15:0]             drop_cnt_o,
    awgn_scale_stream_if.master     out_if
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SH    = FRAC + IN_W - OUT_W;
    localparam int P_W   = IN_W + GAIN_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WC_W  = $clog2(WARMUP + 1);

    localparam logic signed [P_W:0] HALF  = {{(P_W-SH+1){1'b0}}, 1'b1, {(SH-1){1'b0}}};
    localparam logic signed [P_W:0] MAX_V = {{(P_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [P_W:0] MIN_V = {{(P_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [OUT_W-1:0] data;
    } entry_t;

    logic                    warm_q;
    logic [WC_W-1:0]         warm_cnt_q;
    logic [15:0]             drop_q;
    logic                    ser_act_q;
    logic [CH_W-1:0]         ser_idx_q;
    logic [NCH*IN_W-1:0]     ser_vec_q;
    logic [GAIN_W-1:0]       ser_gain_q;
    logic signed [P_W-1:0]   prod_q;
    logic                    prod_v_q;
    logic [CH_W-1:0]         prod_ch_q;
    logic [OUT_W-1:0]        res_q;
    logic                    res_v_q;
    logic [CH_W-1:0]         res_ch_q;
    entry_t                  mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    offered, ser_idle, accept, drop, push, pop;
    int                      ser_rem, credit;
    logic signed [IN_W-1:0]  x_cur;
    logic signed [P_W-1:0]   prod_d;
    logic signed [P_W:0]     rnd, rnd_sh;
    logic [OUT_W-1:0]        res_d;
    entry_t                  head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The serialiser frees up on the cycle its last channel enters the multiplier.
    assign offered  = enable_i & in_valid_i;
    assign ser_idle = !ser_act_q || (ser_idx_q == CH_W'(NCH - 1));
    assign push     = res_v_q;
    assign pop      = out_if.out_valid & out_if.out_ready;
    assign x_cur    = ser_vec_q[int'(ser_idx_q)*IN_W +: IN_W];
    assign prod_d   = x_cur * $signed({1'b0, ser_gain_q});
    assign head     = mem_q[rd_ptr_q];

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        ser_rem = ser_act_q ? (NCH - int'(ser_idx_q)) : 0;
        credit  = DEPTH - int'(count_q) - ser_rem - int'(prod_v_q) - int'(res_v_q);
        accept  = offered && warm_q && ser_idle && (credit >= NCH);
        drop    = offered && warm_q && !accept;
        rnd     = {prod_q[P_W-1], prod_q} + HALF;
        rnd_sh  = rnd >>> SH;
        if (rnd_sh > MAX_V)      res_d = MAX_V[OUT_W-1:0];
        else if (rnd_sh < MIN_V) res_d = MIN_V[OUT_W-1:0];
        else                     res_d = rnd_sh[OUT_W-1:0];
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_q     <= 1'b0;
            warm_cnt_q <= '0;
            drop_q     <= '0;
            ser_act_q  <= 1'b0;
            ser_idx_q  <= '0;
            ser_vec_q  <= '0;
            ser_gain_q <= '0;
            prod_q     <= '0;
            prod_v_q   <= 1'b0;
            prod_ch_q  <= '0;
            res_q      <= '0;
            res_v_q    <= 1'b0;
            res_ch_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (offered && !warm_q) begin
                warm_cnt_q <= warm_cnt_q + 1'b1;
                if (warm_cnt_q == WC_W'(WARMUP - 1)) warm_q <= 1'b1;
            end
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;

            if (accept) begin
                ser_act_q  <= 1'b1;
                ser_idx_q  <= '0;
                ser_vec_q  <= in_data_i;
                ser_gain_q <= gain_i;
            end else if (ser_act_q) begin
                if (ser_idx_q == CH_W'(NCH - 1)) ser_act_q <= 1'b0;
                else                             ser_idx_q <= ser_idx_q + 1'b1;
            end

            prod_q    <= prod_d;
            prod_v_q  <= ser_act_q;
            prod_ch_q <= ser_idx_q;
            res_q     <= res_d;
            res_v_q   <= prod_v_q;
            res_ch_q  <= prod_ch_q;

            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{ch: res_ch_q, data: res_q};
    end

    assign out_if.out_valid = (count_q != '0);
    assign out_if.out_data  = out_if.out_valid ? head.data : '0;
    assign out_if.out_ch    = out_if.out_valid ? head.ch : '0;
    assign out_if.out_last  = out_if.out_valid && (head.ch == CH_W'(NCH - 1));
    assign warm_o           = warm_q;
    assign drop_cnt_o       = drop_q;
endmodule
